reg_file_param: RTL and testbench
=================================

// Module: reg_file_param
// PURPOSE
//  Parametrised, clocked register file for the mini-MIPS datapath. Replaces the fixed 8x32 file.
//  Two combinational read ports and one synchronous write port with byte enables.
//  Optional write-to-read bypass and an optional hardwired-zero register 0.
//  A sequenced bulk-clear engine zeroes the array one entry per cycle.
// PARAMETERS
//  DATA_W    32  width of each register in bits (multiple of 8)
//  ADDR_W    3   address width; DEPTH = 2**ADDR_W entries
//  ZERO_REG  1   1: register 0 always reads 0 and ignores writes
//  BYPASS    1   1: a same-cycle write to the read address is forwarded to the read port
// PORTS
//  clk            in   1         rising-edge clock
//  rst_n          in   1         asynchronous active-low reset
//  RegWrite       in   1         write enable, sampled at posedge clk
//  WriteRegister  in   ADDR_W    write address
//  WriteData      in   DATA_W    write data
//  ByteEn         in   DATA_W/8  per-byte write mask; bit i covers WriteData[8i+7:8i]
//  RegReadA       in   ADDR_W    read address, port A
//  RegReadB       in   ADDR_W    read address, port B
//  ReadDataA      out  DATA_W    read data, port A (combinational)
//  ReadDataB      out  DATA_W    read data, port B (combinational)
//  ClearReq       in   1         request a bulk clear, sampled at posedge clk
//  ClearBusy      out  1         high while the clear engine runs
//  ClearDone      out  1         one-cycle pulse after the last entry has been cleared
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous)
//   - All entries become 0. The FSM goes to IDLE and the clear index to 0.
//   - ClearBusy=0, ClearDone=0.
//   - ReadDataA/B therefore show 0.
//  Write
//   - At posedge, if RegWrite && !ClearBusy: storage[WriteRegister] byte i <= WriteData byte i for every ByteEn[i]=1.
//   - Bytes with ByteEn[i]=0 keep their value. ByteEn=0 means no change.
//   - If ZERO_REG=1 and WriteRegister=0, the write is dropped.
//  Read
//   - ReadDataX = storage[RegReadX] combinationally. It reads 0 when ZERO_REG=1 and RegReadX=0.
//   - Bypass (BYPASS=1): if RegWrite && !ClearBusy && RegReadX==WriteRegister (and not the zero register),
//     ReadDataX shows the merged value: new bytes where ByteEn=1, stored bytes elsewhere.
//   - With BYPASS=0, the new value is visible from the cycle after the write edge.
//   - Both ports may read the same address, including the bypassed one.
//  Clear FSM: states IDLE, CLEAR, DONE
//   - IDLE: ClearReq=1 at posedge -> CLEAR; idx<=0.
//   - CLEAR: each posedge, storage[idx]<=0 and idx<=idx+1. When idx==DEPTH-1 -> DONE. Takes DEPTH cycles.
//   - DONE: ClearDone=1 for exactly one cycle -> IDLE.
//   - ClearBusy=1 in CLEAR only.
//   - RegWrite is ignored (dropped, not queued) while ClearBusy=1.
//   - ClearReq is ignored in CLEAR and DONE.
//   - Reads during CLEAR return current contents: cleared entries read 0, the rest keep their old data.
//   - A write coincident with the ClearReq edge in IDLE is performed. The clear then overwrites it.
//   - idx is ADDR_W bits and wraps only through the DONE transition.
//   - rst_n low mid-clear: immediate IDLE, array zeroed, no ClearDone pulse.
//  Latency: read 0 cycles; write 1 edge; full clear DEPTH+1 cycles from request to ClearDone.
// STRUCTURE
//  - Shared package mips_pkg: the clear-state enum (IDLE/CLEAR/DONE) and default DATA_W/ADDR_W constants.
//  - One sub-module, rf_byte_merge: combinational merge(old, new, ByteEn), used for the write path and both bypass paths.
//  - Storage is an unpacked array named storage, kept visible for $writememb dumps.
// TESTING (default parameters)
//  1. Reset: rst_n=0 then 1; read all 8 entries -> all 0; ClearBusy=0, ClearDone=0.
//  2. Write r2=32'h5555_5555 with ByteEn=4'hF, next cycle RegReadA=2 -> 32'h5555_5555.
//     Then write r2=32'hFFFF_0000 with ByteEn=4'b1100 -> r2 reads 32'hFFFF_5555.
//  3. Bypass: in the same cycle as writing r7=32'h0000_FFFF, RegReadB=7 -> 32'h0000_FFFF before the edge.
//     With BYPASS=0 it returns the old value until after the edge.
//  4. Zero register: write r0=32'hFFFF_FFFF -> ReadDataA with RegReadA=0 returns 0.
//     With ZERO_REG=0 it returns 32'hFFFF_FFFF.
//  5. Clear: fill r1..r7 with nonzero values, pulse ClearReq -> ClearBusy high for 8 cycles.
//     A RegWrite of r3 mid-clear is dropped. ClearDone pulses once; all entries read 0.
//  6. Reset mid-clear: assert rst_n=0 at clear cycle 4 -> ClearBusy=0 immediately, all entries 0, no ClearDone.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared clear-FSM state type and default register-file geometry
package mips_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 3;
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_e;
endpackage

// File: rtl/reg_file_param_if.sv
// reg_file_param_if: register-file bus; master drives writes, reads and clear requests, slave returns data and clear status
interface reg_file_param_if #(
  parameter int DATA_W = mips_pkg::DEF_DATA_W,
  parameter int ADDR_W = mips_pkg::DEF_ADDR_W
);
  logic                RegWrite;
  logic [ADDR_W-1:0]   WriteRegister;
  logic [DATA_W-1:0]   WriteData;
  logic [DATA_W/8-1:0] ByteEn;
  logic [ADDR_W-1:0]   RegReadA;
  logic [ADDR_W-1:0]   RegReadB;
  logic [DATA_W-1:0]   ReadDataA;
  logic [DATA_W-1:0]   ReadDataB;
  logic                ClearReq;
  logic                ClearBusy;
  logic                ClearDone;
  modport master (output RegWrite, WriteRegister, WriteData, ByteEn, RegReadA, RegReadB, ClearReq,
                  input  ReadDataA, ReadDataB, ClearBusy, ClearDone);
  modport slave  (input  RegWrite, WriteRegister, WriteData, ByteEn, RegReadA, RegReadB, ClearReq,
                  output ReadDataA, ReadDataB, ClearBusy, ClearDone);
endinterface

// File: rtl/rf_byte_merge.sv
// rf_byte_merge: per-byte select of i_new over i_old under i_be (o_data = merged word)
module rf_byte_merge #(
  parameter int DATA_W = mips_pkg::DEF_DATA_W
) (
  input  logic [DATA_W-1:0]   i_old,
  input  logic [DATA_W-1:0]   i_new,
  input  logic [DATA_W/8-1:0] i_be,
  output logic [DATA_W-1:0]   o_data
);
  for (genvar b = 0; b < DATA_W/8; b++) begin : g_byte
    assign o_data[8*b +: 8] = i_be[b] ? i_new[8*b +: 8] : i_old[8*b +: 8];
  end
endmodule

// File: rtl/reg_file_param.sv
// reg_file_param: 2R/1W byte-enabled register file with optional bypass, zero register and bulk-clear engine
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of reg_file_param_if (write/read ports, ClearReq/ClearBusy/ClearDone)
module reg_file_param import mips_pkg::*; #(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  reg_file_param_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DATA_W-1:0] storage [DEPTH];
  clr_state_e        r_state;
  logic [ADDR_W-1:0] r_idx;
  logic              w_busy, w_wr, w_hit_a, w_hit_b;
  logic [DATA_W-1:0] w_wdata, w_byp_a, w_byp_b;
  assign w_busy  = r_state == CLEAR;
  assign w_wr    = bus.RegWrite && !w_busy && !(ZERO_REG && bus.WriteRegister == '0);
  assign w_hit_a = BYPASS && w_wr && bus.RegReadA == bus.WriteRegister;
  assign w_hit_b = BYPASS && w_wr && bus.RegReadB == bus.WriteRegister;
  rf_byte_merge #(.DATA_W(DATA_W)) u_merge_w (.i_old(storage[bus.WriteRegister]), .i_new(bus.WriteData), .i_be(bus.ByteEn), .o_data(w_wdata));
  rf_byte_merge #(.DATA_W(DATA_W)) u_merge_a (.i_old(storage[bus.RegReadA]), .i_new(bus.WriteData), .i_be(bus.ByteEn), .o_data(w_byp_a));
  rf_byte_merge #(.DATA_W(DATA_W)) u_merge_b (.i_old(storage[bus.RegReadB]), .i_new(bus.WriteData), .i_be(bus.ByteEn), .o_data(w_byp_b));
  assign bus.ReadDataA = (ZERO_REG && bus.RegReadA == '0) ? '0 : w_hit_a ? w_byp_a : storage[bus.RegReadA];
  assign bus.ReadDataB = (ZERO_REG && bus.RegReadB == '0) ? '0 : w_hit_b ? w_byp_b : storage[bus.RegReadB];
  assign bus.ClearBusy = w_busy;
  assign bus.ClearDone = r_state == DONE;
  // Writes are blocked while busy, so the clear store below never collides with a user write.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) storage[i] <= '0;
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      if (w_wr) storage[bus.WriteRegister] <= w_wdata;
      case (r_state)
        IDLE: if (bus.ClearReq) begin
          r_state <= CLEAR;
          r_idx   <= '0;
        end
        CLEAR: begin
          storage[r_idx] <= '0;
          r_idx          <= r_idx + 1'b1;
          if (r_idx == ADDR_W'(DEPTH-1)) r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_reg_file_param.sv
// tb_reg_file_param: random + directed scoreboard bench for reg_file_param (default and no-bypass/no-zero-reg variants)
module tb_reg_file_param;
  localparam int DEPTH = 8;
  logic clk, rst_n;
  reg_file_param_if #(.DATA_W(32), .ADDR_W(3)) bus ();
  reg_file_param_if #(.DATA_W(32), .ADDR_W(3)) bus2 ();
  reg_file_param #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  reg_file_param #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  assign bus2.RegWrite      = bus.RegWrite;
  assign bus2.WriteRegister = bus.WriteRegister;
  assign bus2.WriteData     = bus.WriteData;
  assign bus2.ByteEn        = bus.ByteEn;
  assign bus2.RegReadA      = bus.RegReadA;
  assign bus2.RegReadB      = bus.RegReadB;
  assign bus2.ClearReq      = bus.ClearReq;
  initial clk = 0;
  always #5 clk = ~clk;
  typedef struct {logic [31:0] a, b, a2, b2; logic busy, done;} exp_t;
  exp_t q[$];
  logic [31:0] m1 [DEPTH];
  logic [31:0] m2 [DEPTH];
  int clr_left = 0;
  bit done_m = 0;
  int n_checks = 0, n_fail = 0;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] mrg(logic [31:0] o, logic [31:0] n, logic [3:0] be);
    logic [31:0] r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction
  function automatic logic [31:0] rd(bit zr, bit bp, logic [31:0] m [DEPTH], int ra, bit we, int wa,
                                     logic [31:0] wd, logic [3:0] be, bit busy);
    if (zr && ra == 0) return 32'h0;
    if (bp && we && !busy && ra == wa && !(zr && wa == 0)) return mrg(m[ra], wd, be);
    return m[ra];
  endfunction
  task automatic step(bit we, int wa, logic [31:0] wd, logic [3:0] be, int ra, int rb, bit cr);
    exp_t e;
    bit busy, pd;
    bus.RegWrite = we; bus.WriteRegister = 3'(wa); bus.WriteData = wd; bus.ByteEn = be;
    bus.RegReadA = 3'(ra); bus.RegReadB = 3'(rb); bus.ClearReq = cr;
    busy = clr_left > 0;
    e.a  = rd(1, 1, m1, ra, we, wa, wd, be, busy);
    e.b  = rd(1, 1, m1, rb, we, wa, wd, be, busy);
    e.a2 = rd(0, 0, m2, ra, we, wa, wd, be, busy);
    e.b2 = rd(0, 0, m2, rb, we, wa, wd, be, busy);
    e.busy = busy;
    e.done = done_m;
    q.push_back(e);
    @(posedge clk); #1;
    pd = done_m;
    done_m = 0;
    if (we && !busy) begin
      if (wa != 0) m1[wa] = mrg(m1[wa], wd, be);
      m2[wa] = mrg(m2[wa], wd, be);
    end
    if (busy) begin
      m1[DEPTH-clr_left] = 0;
      m2[DEPTH-clr_left] = 0;
      clr_left--;
      done_m = clr_left == 0;
    end else if (cr && !pd) clr_left = DEPTH;
  endtask
  always @(negedge clk) if (q.size() > 0) begin : mon
    exp_t e;
    e = q.pop_front();
    chk("rdA",       bus.ReadDataA,  e.a);
    chk("rdB",       bus.ReadDataB,  e.b);
    chk("rdA_nobyp", bus2.ReadDataA, e.a2);
    chk("rdB_nobyp", bus2.ReadDataB, e.b2);
    chk("busy",      32'(bus.ClearBusy), 32'(e.busy));
    chk("done",      32'(bus.ClearDone), 32'(e.done));
  end
  initial begin
    for (int i = 0; i < DEPTH; i++) begin m1[i] = 0; m2[i] = 0; end
    bus.RegWrite = 0; bus.WriteRegister = 0; bus.WriteData = 0; bus.ByteEn = 0;
    bus.RegReadA = 0; bus.RegReadB = 0; bus.ClearReq = 0;
    rst_n = 0;
    #12;
    chk("rst_busy", 32'(bus.ClearBusy), 32'h0);
    chk("rst_done", 32'(bus.ClearDone), 32'h0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 0, i, DEPTH-1-i, 0);
    step(1, 2, 32'h5555_5555, 4'hF, 2, 2, 0);
    step(0, 0, 0, 0, 2, 2, 0);
    step(1, 2, 32'hFFFF_0000, 4'hC, 1, 2, 0);
    step(0, 0, 0, 0, 2, 1, 0);
    step(1, 7, 32'h0000_FFFF, 4'hF, 2, 7, 0);
    step(0, 0, 0, 0, 7, 7, 0);
    step(1, 4, 32'hAAAA_AAAA, 4'h0, 4, 4, 0);
    step(1, 0, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    step(0, 0, 0, 0, 0, 7, 0);
    for (int i = 1; i < DEPTH; i++) step(1, i, 32'h1111_1111 * i, 4'hF, i, i-1, 0);
    step(1, 5, 32'hCAFE_F00D, 4'hF, 5, 3, 1);
    for (int i = 0; i < DEPTH + 3; i++) step(i == 3, 3, 32'h3333_3333, 4'hF, (i+2) % DEPTH, 3, i == 8);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 0, i, (i+5) % DEPTH, 0);
    step(1, 5, 32'hDEAD_BEEF, 4'hF, 5, 6, 0);
    step(1, 6, 32'h1234_5678, 4'hF, 5, 6, 0);
    step(0, 0, 0, 0, 5, 6, 1);
    repeat (4) step(0, 0, 0, 0, 5, 6, 0);
    rst_n = 0;
    #1;
    chk("midrst_busy", 32'(bus.ClearBusy), 32'h0);
    chk("midrst_done", 32'(bus.ClearDone), 32'h0);
    chk("midrst_r5", bus.ReadDataA, 32'h0);
    chk("midrst_r6", bus2.ReadDataB, 32'h0);
    for (int i = 0; i < DEPTH; i++) begin m1[i] = 0; m2[i] = 0; end
    clr_left = 0;
    done_m = 0;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    for (int i = 0; i < DEPTH + 3; i++) step(0, 0, 0, 0, i % DEPTH, 5, 0);
    for (int n = 0; n < 500; n++)
      step($urandom_range(0, 2) != 0, $urandom_range(0, 7), $urandom, 4'($urandom),
           $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 40) == 0);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 0, i, DEPTH-1-i, 0);
    @(negedge clk); @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
